fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined processor. It sits directly upstream of the decode-stage controller. It owns the fetch program counter (PCF) and the single-outstanding instruction-memory handshake. It registers the fetched word, its PC+8 and a valid bit into the F/D pipeline register, which supplies the Instr/Cond fields decoded by the controller. It honours the hazard unit's StallF/StallD/FlushD and redirects on BranchTakenE (execute) or PCSrcW (writeback).

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// One request in flight at a time; the response strobe carries the word.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_valid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, the single-outstanding imem handshake and the
// F/D pipeline register feeding decode.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    fetch_stage_if.master    imem,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } state_e;

    localparam logic [WIDTH-1:0] FOUR  = WIDTH'(4);
    localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pcf_q, pcf_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc8_q, pc8_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    logic             redir;
    logic [WIDTH-1:0] redir_pc;
    logic             load;
    logic [WIDTH-1:0] ld_word;

    assign redir    = BranchTakenE | PCSrcW;
    assign redir_pc = BranchTakenE ? ALUResultE : ResultW;

    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        instr_d = instr_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        load    = 1'b0;
        ld_word = '0;

        unique case (state_q)
            ISSUE: state_d = redir ? DROP : WAIT;
            WAIT: begin
                if (imem.imem_valid) begin
                    state_d = ISSUE;
                    if (!redir) begin
                        if (StallD && !FlushD) begin
                            hold_d  = imem.imem_rdata;
                            state_d = HOLD;
                        end else begin
                            load    = 1'b1;
                            ld_word = imem.imem_rdata;
                        end
                    end
                end else if (redir) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redir) begin
                    state_d = ISSUE;
                end else if (!StallD || FlushD) begin
                    load    = 1'b1;
                    ld_word = hold_q;
                    state_d = ISSUE;
                end
            end
            // A stale response retires the drop even under a new redirect.
            DROP: if (imem.imem_valid) state_d = ISSUE;
        endcase

        if (load && !StallF) pcf_d = pcf_q + FOUR;
        if (redir) pcf_d = redir_pc;

        if (FlushD) begin
            instr_d = '0;
            pc8_d   = '0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            if (load) begin
                instr_d = ld_word;
                pc8_d   = pcf_q + EIGHT;
                valid_d = 1'b1;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ISSUE;
            pcf_q   <= RESET_PC;
            instr_q <= '0;
            pc8_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign imem.imem_req  = reset && (state_q == ISSUE);
    assign imem.imem_addr = pcf_q;
    assign PCF            = pcf_q;
    assign InstrD         = instr_q;
    assign PCPlus8D       = pc8_q;
    assign ValidD         = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-cycle-latency imem model.
// Expected values are hand-computed per cycle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD;

    int n_chk = 0;
    int n_err = 0;

    logic        pend;
    logic [31:0] paddr;

    fetch_stage_if #(.WIDTH(32)) imem ();

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .imem         (imem),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] W(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nx;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    // imem model: request seen in cycle t, response strobed in cycle t+1
    initial begin
        pend             = 1'b0;
        paddr            = '0;
        imem.imem_valid  = 1'b0;
        imem.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (reset && imem.imem_req) begin
                pend  = 1'b1;
                paddr = imem.imem_addr;
            end
            @(posedge clk);
            #1;
            imem.imem_valid = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else if (pend) begin
                imem.imem_valid = 1'b1;
                imem.imem_rdata = W(paddr);
                pend            = 1'b0;
            end
        end
    end

    initial begin
        reset        = 1'b0;
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        BranchTakenE = 1'b0;
        PCSrcW       = 1'b0;
        ALUResultE   = '0;
        ResultW      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_vld", {31'd0, ValidD}, 32'd0);

        // sequential fetch 0,4,8
        do_reset();
        chk("t1_req0", {31'd0, imem.imem_req}, 32'd1);
        chk("t1_adr0", imem.imem_addr, 32'h0);
        nx; nx;
        chk("t1_ins0", InstrD, W(32'h0));
        chk("t1_vld0", {31'd0, ValidD}, 32'd1);
        chk("t1_pc80", PCPlus8D, 32'd8);
        chk("t1_adr1", imem.imem_addr, 32'h4);
        nx; nx;
        chk("t1_ins1", InstrD, W(32'h4));
        chk("t1_pc81", PCPlus8D, 32'd12);
        chk("t1_adr2", imem.imem_addr, 32'h8);
        nx; nx;
        chk("t1_ins2", InstrD, W(32'h8));
        chk("t1_pc82", PCPlus8D, 32'd16);

        // StallD across the 0x4 response
        do_reset();
        nx; nx;
        StallD = 1'b1;
        nx;
        chk("t2_hld0", InstrD, W(32'h0));
        nx;
        chk("t2_noreq", {31'd0, imem.imem_req}, 32'd0);
        chk("t2_hld1", InstrD, W(32'h0));
        nx;
        chk("t2_hld2", InstrD, W(32'h0));
        StallD = 1'b0;
        nx;
        chk("t2_ins", InstrD, W(32'h4));
        chk("t2_pc8", PCPlus8D, 32'hC);
        chk("t2_vld", {31'd0, ValidD}, 32'd1);
        chk("t2_adr", imem.imem_addr, 32'h8);

        // branch in the ISSUE cycle of 0x8
        BranchTakenE = 1'b1;
        ALUResultE   = 32'h100;
        nx;
        BranchTakenE = 1'b0;
        chk("t3_adr", imem.imem_addr, 32'h100);
        chk("t3_noreq", {31'd0, imem.imem_req}, 32'd0);
        chk("t3_vld", {31'd0, ValidD}, 32'd0);
        nx;
        chk("t3_drop", InstrD, 32'h0);
        chk("t3_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t3_adr2", imem.imem_addr, 32'h100);
        nx; nx;
        chk("t3_ins", InstrD, W(32'h100));
        chk("t3_pc8", PCPlus8D, 32'h108);

        // simultaneous redirects: execute wins
        PCSrcW       = 1'b1;
        ResultW      = 32'h200;
        BranchTakenE = 1'b1;
        ALUResultE   = 32'h300;
        nx;
        PCSrcW       = 1'b0;
        BranchTakenE = 1'b0;
        chk("t4_pcf", PCF, 32'h300);
        nx;
        chk("t4_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t4_adr", imem.imem_addr, 32'h300);

        // flush with a response in the same cycle
        nx;
        FlushD = 1'b1;
        nx;
        FlushD = 1'b0;
        chk("t5_ins", InstrD, 32'h0);
        chk("t5_vld", {31'd0, ValidD}, 32'd0);
        chk("t5_pc8", PCPlus8D, 32'h0);
        chk("t5_pcf", PCF, 32'h304);

        // asynchronous reset while in WAIT
        nx; nx;
        chk("t6_pre", InstrD, W(32'h304));
        StallD = 1'b1;
        nx;
        reset = 1'b0;
        #1;
        chk("t6_pcf", PCF, 32'h0);
        chk("t6_ins", InstrD, 32'h0);
        chk("t6_pc8", PCPlus8D, 32'h0);
        chk("t6_vld", {31'd0, ValidD}, 32'd0);
        chk("t6_req", {31'd0, imem.imem_req}, 32'd0);
        StallD = 1'b0;

        // PC adders wrap at the top of the address space
        do_reset();
        BranchTakenE = 1'b1;
        ALUResultE   = 32'hFFFF_FFFC;
        nx;
        BranchTakenE = 1'b0;
        nx;
        chk("t7_adr", imem.imem_addr, 32'hFFFF_FFFC);
        nx; nx;
        chk("t7_ins", InstrD, W(32'hFFFF_FFFC));
        chk("t7_pc8", PCPlus8D, 32'h4);
        chk("t7_wrap", imem.imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
